// File: rtl/rv32_pkg.sv
// Shared RV32I datapath constants and types used by the PC register slice.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 32'h0000_0000;
  localparam pc_t PC_INC       = 32'd4;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational PC + 4 adder feeding the sequential-fetch and link paths.
module pc_incrementer #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  import rv32_pkg::*;

  // Carry-out is deliberately dropped so the top word wraps to zero.
  assign pc_plus4 = pc + XLEN'(PC_INC);

endmodule

// File: rtl/pc_reg.sv
// Program-counter register for the RV32I single-cycle core.
// Optional word-alignment enforcement via macro PC_ALIGN_CHECK_EN.
module pc_reg #(
  parameter int              XLEN         = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32_pkg::RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_misalign
);
  import rv32_pkg::*;

  logic [XLEN-1:0] pc_value_reg;
  logic [XLEN-1:0] load_value;

`ifdef PC_ALIGN_CHECK_EN
  // Flag is forced low in reset so the outputs stay quiet until the core runs.
  assign pc_misalign = pc_en & ~rst & (pc_next[1:0] != 2'b00);
  assign load_value  = {pc_next[XLEN-1:2], 2'b00};
`else
  assign pc_misalign = 1'b0;
  assign load_value  = pc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_value_reg <= RESET_VECTOR;
    end else if (pc_en) begin
      pc_value_reg <= load_value;
    end
  end

  assign pc_current = pc_value_reg;

  pc_incrementer #(
    .XLEN (XLEN)
  ) u_pc_incrementer (
    .pc       (pc_value_reg),
    .pc_plus4 (pc_plus4)
  );

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed scenarios plus randomized run vs. a reference model.
module tb_pc_reg;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic [31:0] pc_next;
  logic [31:0] pc_current;
  logic [31:0] pc_plus4;
  logic        pc_misalign;

  int n_cmp;
  int n_bad;

  pc_reg dut (
    .clk         (clk),
    .rst         (rst),
    .pc_en       (pc_en),
    .pc_next     (pc_next),
    .pc_current  (pc_current),
    .pc_plus4    (pc_plus4),
    .pc_misalign (pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Value the PC register takes when a load happens.
  function automatic logic [31:0] loaded(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return v & ~32'h3;
`else
    return v;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; pc_en = 1'b1; pc_next = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (pc_current !== RST_VEC) begin
      n_bad++; $display("FAIL reset_async: pc_current=%h expected=%h", pc_current, RST_VEC);
    end
    n_cmp++;
    if (pc_misalign !== 1'b0) begin
      n_bad++; $display("FAIL reset_misalign: pc_misalign=%b expected=0", pc_misalign);
    end
    edge_step();
    n_cmp++;
    if (pc_current !== RST_VEC) begin
      n_bad++; $display("FAIL reset_edge: pc_current=%h expected=%h", pc_current, RST_VEC);
    end
    n_cmp++;
    if (pc_plus4 !== 32'h4) begin
      n_bad++; $display("FAIL reset_plus4: pc_plus4=%h expected=%h", pc_plus4, 32'h4);
    end
    $display("txn reset: pc_current=%h", pc_current);
  endtask

  task automatic test_basic_load();
    rst = 1'b0; pc_en = 1'b1; pc_next = 32'h0000_0004;
    edge_step();
    n_cmp++;
    if (pc_current !== 32'h4) begin
      n_bad++; $display("FAIL basic_load: pc_current=%h expected=%h", pc_current, 32'h4);
    end
    n_cmp++;
    if (pc_plus4 !== 32'h8) begin
      n_bad++; $display("FAIL basic_plus4: pc_plus4=%h expected=%h", pc_plus4, 32'h8);
    end
    $display("txn load: pc_current=%h pc_plus4=%h", pc_current, pc_plus4);
  endtask

  task automatic test_sequential();
    logic [31:0] vals [3];
    vals[0] = 32'h0000_0008; vals[1] = 32'h0000_000C; vals[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      pc_next = vals[i];
      edge_step();
      n_cmp++;
      if (pc_current !== vals[i]) begin
        n_bad++; $display("FAIL seq_load[%0d]: pc_current=%h expected=%h", i, pc_current, vals[i]);
      end
      n_cmp++;
      if (pc_plus4 !== vals[i] + 32'd4) begin
        n_bad++; $display("FAIL seq_plus4[%0d]: pc_plus4=%h expected=%h", i, pc_plus4, vals[i] + 32'd4);
      end
      $display("txn seq[%0d]: pc_current=%h", i, pc_current);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; pc_next = 32'h1234_5678;
    #1;
    n_cmp++;
    if (pc_current !== RST_VEC) begin
      n_bad++; $display("FAIL midreset_async: pc_current=%h expected=%h", pc_current, RST_VEC);
    end
    edge_step();
    n_cmp++;
    if (pc_current !== RST_VEC) begin
      n_bad++; $display("FAIL midreset_edge: pc_current=%h expected=%h", pc_current, RST_VEC);
    end
    rst = 1'b0; pc_next = 32'h0000_0100;
    edge_step();
    n_cmp++;
    if (pc_current !== 32'h100) begin
      n_bad++; $display("FAIL midreset_release: pc_current=%h expected=%h", pc_current, 32'h100);
    end
    $display("txn midreset: pc_current=%h", pc_current);
  endtask

  task automatic test_stall_wrap();
    pc_en = 1'b0; pc_next = 32'h0000_0200;
    edge_step();
    n_cmp++;
    if (pc_current !== 32'h100) begin
      n_bad++; $display("FAIL stall_hold: pc_current=%h expected=%h", pc_current, 32'h100);
    end
    n_cmp++;
    if (pc_misalign !== 1'b0) begin
      n_bad++; $display("FAIL stall_misalign: pc_misalign=%b expected=0", pc_misalign);
    end
    pc_en = 1'b1; pc_next = 32'hFFFF_FFFC;
    edge_step();
    n_cmp++;
    if (pc_current !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_load: pc_current=%h expected=%h", pc_current, 32'hFFFF_FFFC);
    end
    n_cmp++;
    if (pc_plus4 !== 32'h0) begin
      n_bad++; $display("FAIL wrap_plus4: pc_plus4=%h expected=%h", pc_plus4, 32'h0);
    end
    $display("txn stall_wrap: pc_current=%h pc_plus4=%h", pc_current, pc_plus4);
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_align();
    pc_en = 1'b1; pc_next = 32'h0000_0106;
    #1;
    n_cmp++;
    if (pc_misalign !== 1'b1) begin
      n_bad++; $display("FAIL align_flag: pc_misalign=%b expected=1", pc_misalign);
    end
    edge_step();
    n_cmp++;
    if (pc_current !== 32'h104) begin
      n_bad++; $display("FAIL align_load: pc_current=%h expected=%h", pc_current, 32'h104);
    end
    $display("txn align: pc_current=%h", pc_current);
  endtask
`endif

  // Reference: PC is a plain variable updated by the architectural rules once per edge.
  task automatic test_random();
    logic [31:0] model_pc;
    logic        exp_mis;
    model_pc = pc_current;
    for (int t = 0; t < 120; t++) begin
      rst     = ($urandom_range(0, 9) == 0);
      pc_en   = ($urandom_range(0, 3) != 0);
      pc_next = $urandom();
      if ($urandom_range(0, 1) == 1) pc_next[1:0] = 2'b00;
      #1;
      if (rst) model_pc = RST_VEC;
`ifdef PC_ALIGN_CHECK_EN
      exp_mis = !rst && pc_en && (pc_next[1:0] != 2'b00);
`else
      exp_mis = 1'b0;
`endif
      n_cmp++;
      if (pc_current !== model_pc) begin
        n_bad++; $display("FAIL rand_pre[%0d]: pc_current=%h expected=%h", t, pc_current, model_pc);
      end
      n_cmp++;
      if (pc_misalign !== exp_mis) begin
        n_bad++; $display("FAIL rand_misalign[%0d]: pc_misalign=%b expected=%b", t, pc_misalign, exp_mis);
      end
      edge_step();
      if (rst) model_pc = RST_VEC;
      else if (pc_en) model_pc = loaded(pc_next);
      n_cmp++;
      if (pc_current !== model_pc) begin
        n_bad++; $display("FAIL rand_pc[%0d]: pc_current=%h expected=%h", t, pc_current, model_pc);
      end
      n_cmp++;
      if (pc_plus4 !== model_pc + 32'd4) begin
        n_bad++; $display("FAIL rand_plus4[%0d]: pc_plus4=%h expected=%h", t, pc_plus4, model_pc + 32'd4);
      end
      $display("txn rand[%0d]: rst=%b en=%b next=%h pc=%h", t, rst, pc_en, pc_next, pc_current);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; pc_en = 1'b0; pc_next = '0;
    test_reset();
    test_basic_load();
    test_sequential();
    test_mid_reset();
    test_stall_wrap();
`ifdef PC_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
